// File: rtl/mult_pkg.sv
// Shared constants for the shift-add multiplier scheduler: default operand
// width and the FSM state encoding used by the scheduler and its bench.
package mult_pkg;

  localparam int N_DEF = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_ADDED = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mult_rr_arb.sv
// Two-requester round-robin arbiter: a 1-bit priority pointer breaks ties,
// and it hands priority to the other requester when an operation retires.
module mult_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  input  logic owner,
  output logic win
);

  logic ptr;

  // Pointer moves to the requester that did not own the finished operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~owner;
    end
  end

  // A lone request wins outright; a tie goes to the pointer.
  always_comb begin
    win = ptr;
    if (req0 && !req1) begin
      win = 1'b0;
    end else if (!req0 && req1) begin
      win = 1'b1;
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Control unit for a shared shift-add multiplier serving two requesters:
// round-robin grant, then Load / (Ad, Sh)* / Done sequencing over N bits.
module mult_scheduler
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic Clk,
  input  logic reset,
  input  logic Req0,
  input  logic Req1,
  input  logic M,
  output logic Gnt0,
  output logic Gnt1,
  output logic Sel,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Idle,
  output logic Done0,
  output logic Done1
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             sel;
  logic [CNT_W-1:0] cnt;
  logic             win;
  logic             any_req;
  logic             busy;

  assign any_req = Req0 || Req1;

  mult_rr_arb u_arb (
    .clk     (Clk),
    .reset   (reset),
    .req0    (Req0),
    .req1    (Req1),
    .advance (state == ST_DONE),
    .owner   (sel),
    .win     (win)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Owner select latched on grant and shift counter, held through the operation.
  always_ff @(posedge Clk) begin
    if (reset) begin
      sel <= 1'b0;
      cnt <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        sel <= win;
      end
      if (state == ST_LOAD) begin
        cnt <= '0;
      end else if (Sh) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic; a shift on the last bit position ends the operation.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = any_req ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (M) begin
          state_nxt = ST_ADDED;
        end else begin
          state_nxt = (cnt == CNT_LAST) ? ST_DONE : ST_CHECK;
        end
      end
      ST_ADDED: state_nxt = (cnt == CNT_LAST) ? ST_DONE : ST_CHECK;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from registered state, owner select and the multiplier LSB.
  always_comb begin
    busy  = (state == ST_LOAD) || (state == ST_CHECK) ||
            (state == ST_ADDED) || (state == ST_DONE);
    Idle  = (state == ST_IDLE);
    Load  = (state == ST_LOAD);
    Ad    = (state == ST_CHECK) && M;
    Sh    = (state == ST_ADDED) || ((state == ST_CHECK) && !M);
    Gnt0  = busy && !sel;
    Gnt1  = busy && sel;
    Done0 = (state == ST_DONE) && !sel;
    Done1 = (state == ST_DONE) && sel;
    Sel   = sel;
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler: a tiny multiplier shift register stands
// in for the datapath, and each cycle's outputs are compared against
// hand-written operation sequences.
module tb_mult_scheduler;
  import mult_pkg::*;

  localparam int N = N_DEF;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  logic Req0 = 1'b0;
  logic Req1 = 1'b0;
  logic M;
  logic Gnt0, Gnt1, Sel, Load, Ad, Sh, Idle, Done0, Done1;

  logic [N-1:0] mreg = '0;
  logic [N-1:0] mult0 = '0;
  logic [N-1:0] mult1 = '0;

  int n_chk = 0;
  int n_fail = 0;

  mult_scheduler #(.N(N)) dut (
    .Clk   (Clk),
    .reset (reset),
    .Req0  (Req0),
    .Req1  (Req1),
    .M     (M),
    .Gnt0  (Gnt0),
    .Gnt1  (Gnt1),
    .Sel   (Sel),
    .Load  (Load),
    .Ad    (Ad),
    .Sh    (Sh),
    .Idle  (Idle),
    .Done0 (Done0),
    .Done1 (Done1)
  );

  always #5 Clk = ~Clk;

  // Multiplier register of the shared datapath
  assign M = mreg[0];
  always @(posedge Clk) begin
    if (Load) mreg <= Sel ? mult1 : mult0;
    else if (Sh) mreg <= mreg >> 1;
  end

  // Output bundle {Gnt0,Gnt1,Load,Ad,Sh,Idle,Done0,Done1}
  function automatic logic [7:0] obs();
    return {Gnt0, Gnt1, Load, Ad, Sh, Idle, Done0, Done1};
  endfunction

  // I=idle L=load A=add S=shift D=done, for owner w
  function automatic logic [7:0] code(byte c, logic w);
    logic [1:0] g;
    g = w ? 2'b01 : 2'b10;
    case (c)
      "L":     return {g, 6'b100000};
      "A":     return {g, 6'b010000};
      "S":     return {g, 6'b001000};
      "D":     return {g, 4'b0000, ~w, w};
      default: return 8'b0000_0100;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_seq(string tag, logic w, string s);
    for (int i = 0; i < s.len(); i++) begin
      step();
      chk($sformatf("%s[%0d]", tag, i), 32'(obs()), 32'(code(s[i], w)));
      if (s[i] != "I") chk($sformatf("%s_sel[%0d]", tag, i), 32'(Sel), 32'(w));
    end
  endtask

  initial begin
    // Reset, then a quiet interval
    reset = 1'b1;
    step();
    chk("rst_state", 32'(obs()), 32'h04);
    chk("rst_sel", 32'(Sel), 32'h0);
    reset = 1'b0;
    expect_seq("quiet", 1'b0, "IIIII");

    // Requester 0, multiplier 1011: Done0 nine cycles after the grant edge
    mult0 = 4'b1011;
    Req0 = 1'b1;
    expect_seq("m1011", 1'b0, "LASASSASD");
    Req0 = 1'b0;
    expect_seq("m1011_end", 1'b0, "I");

    // Requester 0, multiplier 0000: four shifts, no add
    mult0 = 4'b0000;
    Req0 = 1'b1;
    expect_seq("m0000", 1'b0, "LSSSSD");
    Req0 = 1'b0;
    expect_seq("m0000_end", 1'b0, "I");

    // Requester 1, reset lands in ADDED: no Done, pointer back to 0
    mult1 = 4'b0001;
    Req1 = 1'b1;
    expect_seq("rst_mid", 1'b1, "LAS");
    reset = 1'b1;
    step();
    chk("rst_mid_abort", 32'(obs()), 32'h04);
    reset = 1'b0;

    // Both requesters held high: alternating grants with an idle gap
    mult0 = 4'b0001;
    mult1 = 4'b0010;
    Req0 = 1'b1;
    Req1 = 1'b1;
    expect_seq("rr0", 1'b0, "LASSSSDI");
    expect_seq("rr1", 1'b1, "LSASSSDI");
    expect_seq("rr2", 1'b0, "LASSSSDI");
    expect_seq("rr3", 1'b1, "LSASSSD");
    Req0 = 1'b0;
    Req1 = 1'b0;
    expect_seq("rr_end", 1'b1, "I");

    // Requester 1 drops its request two cycles into the operation
    mult1 = 4'b0011;
    Req1 = 1'b1;
    expect_seq("drop_a", 1'b1, "LA");
    Req1 = 1'b0;
    expect_seq("drop_b", 1'b1, "SASSSDII");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
